// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the SRAM arbiter: FSM state encoding, requester
// port identifiers and the byte-lane helper used by the strobe decoder.
package sram_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LO_SETUP  = 3'd1,
        ST_LO_STROBE = 3'd2,
        ST_HI_SETUP  = 3'd3,
        ST_HI_STROBE = 3'd4,
        ST_DONE      = 3'd5
    } state_t;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    // Active-low {ub_n, lb_n} for one halfword. Reads always enable both
    // lanes; writes enable exactly the lanes whose byte enables are set.
    function automatic logic [1:0] lane_n(input logic is_write, input logic [1:0] be);
        return is_write ? ~be : 2'b00;
    endfunction

endpackage

// File: rtl/sram_arbiter_rr_arb.sv
// sram_rr_arb: two-way round-robin arbiter between instruction fetch and data.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   i_en            arbitration allowed this cycle (main FSM is idle)
//   i_req_if        instruction-fetch request
//   i_req_d         data request
//   o_grant         a port is granted this cycle
//   o_port          granted port (PORT_IF / PORT_D), valid with o_grant
module sram_rr_arb
    import sram_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_req_if,
    input  logic i_req_d,
    output logic o_grant,
    output logic o_port
);

    logic r_last;

    always_comb begin
        o_grant = i_en & (i_req_if | i_req_d);
        if (i_req_if && i_req_d) begin
            // Tie: favour whichever port was not served last.
            o_port = (r_last == PORT_D) ? PORT_IF : PORT_D;
        end else begin
            o_port = i_req_d ? PORT_D : PORT_IF;
        end
    end

    // Starting from "data" means instruction fetch wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= PORT_D;
        end else if (o_grant) begin
            r_last <= o_port;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one 16-bit asynchronous SRAM between an instruction
// fetch port and a data port. Each 32-bit word access is split into a low and
// a high halfword, each with one setup cycle and WAIT_CYCLES strobe cycles,
// followed by a single completion cycle that pulses the granted port's ack.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   if_req/if_addr/if_rdata/if_ack   instruction fetch (read only)
//   d_req/d_we/d_addr/d_be/d_wdata   data request
//   d_rdata/d_ack                    data completion
//   sram_addr                        halfword address {word_addr, half}
//   sram_data                        bidirectional SRAM data bus
//   sram_ce_n/oe_n/we_n              active-low SRAM strobes
//   sram_ub/sram_lb                  active-low byte lanes
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [17:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [17:0] d_addr,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic [18:0] sram_addr,
    inout  wire  [15:0] sram_data,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic        sram_ub,
    output logic        sram_lb
);

    localparam logic [2:0] LAST_CNT = 3'(WAIT_CYCLES - 1);

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_cnt;
    logic        r_port;
    logic        r_we;
    logic [17:0] r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [15:0] r_lo;
    logic [15:0] r_hi;

    logic        w_grant;
    logic        w_port;
    logic        w_strobe;
    logic        w_last;
    logic        w_hi;
    logic        w_drive;
    logic [15:0] w_wdata_half;
    logic [1:0]  w_half_be;

    sram_rr_arb u_arb (
        .clk      (clk),
        .rst      (rst),
        .i_en     (r_state == ST_IDLE),
        .i_req_if (if_req),
        .i_req_d  (d_req),
        .o_grant  (w_grant),
        .o_port   (w_port)
    );

    assign w_strobe     = (r_state == ST_LO_STROBE) || (r_state == ST_HI_STROBE);
    assign w_last       = w_strobe && (r_cnt == LAST_CNT);
    assign w_hi         = (r_state == ST_HI_SETUP) || (r_state == ST_HI_STROBE);
    assign w_half_be    = w_hi ? r_be[3:2] : r_be[1:0];
    assign w_wdata_half = w_hi ? r_wdata[31:16] : r_wdata[15:0];

    // The bus is only ever driven for writes, which never assert oe_n.
    assign sram_data = w_drive ? w_wdata_half : 16'hzzzz;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:      if (w_grant) w_next = ST_LO_SETUP;
            ST_LO_SETUP:  w_next = ST_LO_STROBE;
            ST_LO_STROBE: if (w_last) w_next = ST_HI_SETUP;
            ST_HI_SETUP:  w_next = ST_HI_STROBE;
            ST_HI_STROBE: if (w_last) w_next = ST_DONE;
            ST_DONE:      w_next = ST_IDLE;
            default:      w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 3'd0;
        end else if (w_strobe && !w_last) begin
            r_cnt <= r_cnt + 3'd1;
        end else begin
            r_cnt <= 3'd0;
        end
    end

    // Request fields are captured at grant; later changes on the inputs are ignored.
    always_ff @(posedge clk) begin
        if (w_grant && !rst) begin
            r_port  <= w_port;
            r_we    <= (w_port == PORT_D) ? d_we : 1'b0;
            r_addr  <= (w_port == PORT_D) ? d_addr : if_addr;
            r_be    <= d_be;
            r_wdata <= d_wdata;
        end
    end

    // Read data is captured on the final strobe cycle of each half.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lo <= 16'h0000;
            r_hi <= 16'h0000;
        end else if (w_last && !r_we) begin
            if (w_hi) begin
                r_hi <= sram_data;
            end else begin
                r_lo <= sram_data;
            end
        end
    end

    always_comb begin
        sram_addr = 19'h0;
        sram_ce_n = 1'b1;
        sram_oe_n = 1'b1;
        sram_we_n = 1'b1;
        sram_ub   = 1'b1;
        sram_lb   = 1'b1;
        w_drive   = 1'b0;
        if_ack    = 1'b0;
        d_ack     = 1'b0;
        if_rdata  = 32'h0;
        d_rdata   = 32'h0;
        case (r_state)
            ST_LO_SETUP, ST_LO_STROBE, ST_HI_SETUP, ST_HI_STROBE: begin
                sram_addr          = {r_addr, w_hi};
                sram_ce_n          = 1'b0;
                sram_oe_n          = r_we;
                {sram_ub, sram_lb} = lane_n(r_we, w_half_be);
                w_drive            = r_we;
                // A half with no enabled bytes still spends its strobe time,
                // keeping write latency fixed, but never pulses we_n.
                if (w_strobe && r_we) begin
                    sram_we_n = ~|w_half_be;
                end
            end
            ST_DONE: begin
                if (r_port == PORT_IF) begin
                    if_ack   = 1'b1;
                    if_rdata = r_we ? 32'h0 : {r_hi, r_lo};
                end else begin
                    d_ack   = 1'b1;
                    d_rdata = r_we ? 32'h0 : {r_hi, r_lo};
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [17:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        d_req;
    logic        d_we;
    logic [17:0] d_addr;
    logic [3:0]  d_be;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic [18:0] sram_addr;
    wire  [15:0] sram_data;
    logic        ce_n, oe_n, we_n, ub, lb;

    // Second instance with WAIT_CYCLES=3; its SRAM returns addr ^ 0xA5A5.
    logic        c3_if_req;
    logic [17:0] c3_if_addr;
    logic [31:0] c3_if_rdata;
    logic        c3_if_ack;
    logic [31:0] c3_d_rdata;
    logic        c3_d_ack;
    logic [18:0] c3_addr;
    wire  [15:0] c3_data;
    logic        c3_ce_n, c3_oe_n, c3_we_n, c3_ub, c3_lb;
    int          c3_oe_cnt = 0;
    int          c3_we_cnt = 0;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        port;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [18:0] a;
        logic        lb;
        logic        ub;
    } wr_t;
    wr_t wlog[$];

    logic [15:0] mem [0:524287];

    always #5 clk = ~clk;

    sram_arbiter #(.WAIT_CYCLES(1)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_be(d_be), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .sram_addr(sram_addr), .sram_data(sram_data),
        .sram_ce_n(ce_n), .sram_oe_n(oe_n), .sram_we_n(we_n),
        .sram_ub(ub), .sram_lb(lb)
    );

    sram_arbiter #(.WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst),
        .if_req(c3_if_req), .if_addr(c3_if_addr), .if_rdata(c3_if_rdata), .if_ack(c3_if_ack),
        .d_req(1'b0), .d_we(1'b0), .d_addr(18'h0), .d_be(4'h0), .d_wdata(32'h0),
        .d_rdata(c3_d_rdata), .d_ack(c3_d_ack),
        .sram_addr(c3_addr), .sram_data(c3_data),
        .sram_ce_n(c3_ce_n), .sram_oe_n(c3_oe_n), .sram_we_n(c3_we_n),
        .sram_ub(c3_ub), .sram_lb(c3_lb)
    );

    // SRAM models
    assign sram_data = (!ce_n && !oe_n) ? mem[sram_addr] : 16'hzzzz;
    assign c3_data   = (!c3_ce_n && !c3_oe_n) ? (c3_addr[15:0] ^ 16'hA5A5) : 16'hzzzz;

    always @(posedge clk) begin
        if (!ce_n && !we_n) begin
            if (!lb) mem[sram_addr][7:0]  = sram_data[7:0];
            if (!ub) mem[sram_addr][15:8] = sram_data[15:8];
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Completion monitor: every ack must match the next scoreboard entry.
    always @(negedge clk) begin
        if (!ce_n && !we_n) wlog.push_back('{sram_addr, lb, ub});
        if (!c3_oe_n) c3_oe_cnt++;
        if (!c3_we_n) c3_we_cnt++;
        if (if_ack || d_ack) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", {if_ack, d_ack}, 2'b00);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("ack_port", {if_ack, d_ack}, e.port ? 2'b01 : 2'b10);
                chk("ack_rdata", d_ack ? d_rdata : if_rdata, e.data);
                chk("other_rdata", d_ack ? if_rdata : d_rdata, 32'h0);
            end
        end
    end

    task automatic run_if(input logic [17:0] a, input int exp_lat, input string tag);
        int lat = 0;
        if_addr = a;
        if_req  = 1'b1;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!if_ack && lat < 40);
        chk({tag, "_lat"}, lat, exp_lat);
        @(posedge clk); #1;
        if_req = 1'b0;
    endtask

    task automatic run_d(input logic we, input logic [17:0] a, input logic [3:0] be,
                         input logic [31:0] wd, input int exp_lat, input string tag);
        int lat = 0;
        d_we    = we;
        d_addr  = a;
        d_be    = be;
        d_wdata = wd;
        d_req   = 1'b1;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!d_ack && lat < 40);
        chk({tag, "_lat"}, lat, exp_lat);
        @(posedge clk); #1;
        d_req = 1'b0;
        d_we  = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 524288; i++) mem[i] = 16'h0;
        rst = 1'b1;
        if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_be = 0; d_wdata = 0;
        c3_if_req = 0; c3_if_addr = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_strobes", {ce_n, oe_n, we_n, ub, lb}, 5'h1f);
        chk("rst_addr", sram_addr, 19'h0);
        chk("rst_acks", {if_ack, d_ack}, 2'b00);
        chk("rst_rdata", {if_rdata, d_rdata}, 64'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Instruction fetch read
        mem[19'h20] = 16'h5678;
        mem[19'h21] = 16'h1234;
        wlog.delete();
        sb.push_back('{1'b0, 32'h12345678});
        run_if(18'h00010, 5, "if_read");
        chk("if_read_no_we", wlog.size(), 0);

        // Partial write at the top of memory
        mem[19'h7FFFE] = 16'h1122;
        mem[19'h7FFFF] = 16'h3344;
        wlog.delete();
        sb.push_back('{1'b1, 32'h0});
        run_d(1'b1, 18'h3FFFF, 4'b0110, 32'hAABBCCDD, 5, "wr0110");
        chk("wr0110_nstrobe", wlog.size(), 2);
        if (wlog.size() == 2) begin
            chk("wr0110_lo", {wlog[0].a, wlog[0].lb, wlog[0].ub}, {19'h7FFFE, 1'b1, 1'b0});
            chk("wr0110_hi", {wlog[1].a, wlog[1].lb, wlog[1].ub}, {19'h7FFFF, 1'b0, 1'b1});
        end
        chk("wr0110_mem_lo", mem[19'h7FFFE], 16'hCC22);
        chk("wr0110_mem_hi", mem[19'h7FFFF], 16'h33BB);
        sb.push_back('{1'b1, 32'h33BBCC22});
        run_d(1'b0, 18'h3FFFF, 4'b0000, 32'h0, 5, "rd_back");

        // Write with an empty high half keeps full latency
        mem[19'h201] = 16'h9999;
        wlog.delete();
        sb.push_back('{1'b1, 32'h0});
        run_d(1'b1, 18'h00100, 4'b0011, 32'h55667788, 5, "wr0011");
        chk("wr0011_nstrobe", wlog.size(), 1);
        chk("wr0011_mem_lo", mem[19'h200], 16'h7788);
        chk("wr0011_mem_hi", mem[19'h201], 16'h9999);

        // Fresh tie after reset: ifetch first, data after
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mem[19'h60] = 16'hBEEF;
        mem[19'h61] = 16'hCAFE;
        sb.push_back('{1'b0, 32'h12345678});
        sb.push_back('{1'b1, 32'hCAFEBEEF});
        fork
            run_if(18'h00010, 5, "tie1_if");
            run_d(1'b0, 18'h00030, 4'b0000, 32'h0, 11, "tie1_d");
        join
        // Lone fetch, then a tie goes to data
        sb.push_back('{1'b0, 32'hCAFEBEEF});
        run_if(18'h00030, 5, "lone_if");
        sb.push_back('{1'b1, 32'h12345678});
        sb.push_back('{1'b0, 32'hCAFEBEEF});
        fork
            run_d(1'b0, 18'h00010, 4'b0000, 32'h0, 5, "tie2_d");
            run_if(18'h00030, 11, "tie2_if");
        join

        // Reset during LO_STROBE of a write
        mem[19'h80] = 16'h0000;
        mem[19'h81] = 16'h0000;
        d_we = 1'b1; d_addr = 18'h00040; d_be = 4'hF; d_wdata = 32'hDEADBEEF;
        d_req = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("pre_rst_we", we_n, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_strobes", {ce_n, oe_n, we_n, ub, lb}, 5'h1f);
        chk("mid_rst_addr", sram_addr, 19'h0);
        chk("mid_rst_ack", d_ack, 1'b0);
        rst = 1'b0;
        d_req = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("aborted_hi_mem", mem[19'h81], 16'h0000);
        sb.push_back('{1'b1, 32'h0});
        run_d(1'b1, 18'h00040, 4'hF, 32'hDEADBEEF, 5, "retry");
        chk("retry_mem", {mem[19'h81], mem[19'h80]}, 32'hDEADBEEF);

        // WAIT_CYCLES=3 read on the second instance
        begin
            int lat = 0;
            int oe0, we0;
            oe0 = c3_oe_cnt;
            we0 = c3_we_cnt;
            c3_if_addr = 18'h00123;
            c3_if_req  = 1'b1;
            do begin
                @(posedge clk); #1;
                lat++;
            end while (!c3_if_ack && lat < 40);
            chk("w3_lat", lat, 9);
            chk("w3_rdata", c3_if_rdata, {16'h0247 ^ 16'hA5A5, 16'h0246 ^ 16'hA5A5});
            chk("w3_d_rdata", c3_d_rdata, 32'h0);
            @(posedge clk); #1;
            c3_if_req = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            chk("w3_oe_cycles", c3_oe_cnt - oe0, 8);
            chk("w3_we_cycles", c3_we_cnt - we0, 0);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
